// File: rtl/iob_regfile_sp_arb.sv
// ============================================================================
// iob_regfile_sp_arb
// Two-requester round-robin front end for a single-port register file,
// with a power-on / on-demand clear sweep (INIT) ahead of normal service (RUN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module iob_regfile_sp_arb #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 21
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              clr_i,
  output logic              init_done_o,
  // requester 0
  input  logic              m0_valid_i,
  output logic              m0_ready_o,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  // requester 1
  input  logic              m1_valid_i,
  output logic              m1_ready_o,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  // register file port
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_addr_o,
  output logic [DATA_W-1:0] rf_d_o,
  input  logic [DATA_W-1:0] rf_d_i
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic              ptr;     // 0: requester 0 wins a tie, 1: requester 1 wins
  logic              arb_en;
  logic              grant0;
  logic              grant1;

  // Arbitration is only open in RUN, clocked, and with no clear pending.
  // The grant is decided from valids and the pointer only, never from ready.
  always_comb begin
    arb_en = cke_i & (state == ST_RUN) & ~clr_i;
    grant0 = arb_en & m0_valid_i & (~m1_valid_i | ~ptr);
    grant1 = arb_en & m1_valid_i & (~m0_valid_i |  ptr);
  end

  assign m0_ready_o  = grant0;
  assign m1_ready_o  = grant1;
  assign init_done_o = (state == ST_RUN);

  // Register file port mux: zero-fill sweep in INIT, granted requester in RUN.
  always_comb begin
    rf_we_o   = 1'b0;
    rf_addr_o = cnt;
    rf_d_o    = '0;
    if (state == ST_INIT) begin
      rf_we_o   = cke_i;
      rf_addr_o = cnt;
      rf_d_o    = '0;
    end else begin
      rf_addr_o = grant1 ? m1_addr_i  : m0_addr_i;
      rf_d_o    = grant1 ? m1_wdata_i : m0_wdata_i;
      rf_we_o   = (grant0 & m0_we_i) | (grant1 & m1_we_i);
    end
  end

  // Controller state, sweep counter and round-robin pointer.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= ST_INIT;
      cnt   <= '0;
      ptr   <= 1'b0;
    end else if (cke_i) begin
      if (state == ST_INIT) begin
        // counter wraps to 0 naturally after the last address
        cnt <= cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state <= ST_RUN;
        end
      end else begin
        if (clr_i) begin
          state <= ST_INIT;
          cnt   <= '0;
        end
        if (grant0) begin
          ptr <= 1'b1;
        end else if (grant1) begin
          ptr <= 1'b0;
        end
      end
    end
  end

  // Read return path: capture the combinational read data in the acceptance
  // cycle and flag it valid for the following cycle only.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      m0_rvalid_o <= 1'b0;
      m1_rvalid_o <= 1'b0;
      m0_rdata_o  <= '0;
      m1_rdata_o  <= '0;
    end else if (cke_i) begin
      m0_rvalid_o <= grant0 & ~m0_we_i;
      m1_rvalid_o <= grant1 & ~m1_we_i;
      if (grant0 && !m0_we_i) begin
        m0_rdata_o <= rf_d_i;
      end
      if (grant1 && !m1_we_i) begin
        m1_rdata_o <= rf_d_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_regfile_sp_arb.sv
// ============================================================================
// tb_iob_regfile_sp_arb
// Directed bench: behavioural register file, hand-computed expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_iob_regfile_sp_arb;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 21;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              cke;
  logic              clr;
  logic              init_done;
  logic              m0_valid, m0_ready, m0_we, m0_rvalid;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic              m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_d_o, rf_d_i;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Behavioural single-port register file with combinational read
  always @(posedge clk) begin
    if (rf_we) mem[rf_addr] <= rf_d_o;
  end
  assign rf_d_i = mem[rf_addr];

  iob_regfile_sp_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .clr_i(clr),
    .init_done_o(init_done),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_we_i(m0_we),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_we_i(m1_we),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
    .rf_we_o(rf_we), .rf_addr_o(rf_addr), .rf_d_o(rf_d_o), .rf_d_i(rf_d_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // advance one clock, land 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one accepted access from requester k, with port-mux checks
  task automatic issue(input int k, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    if (k == 0) begin
      m0_valid = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
    end else begin
      m1_valid = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
    end
    #1;
    check($sformatf("issue%0d_ready", k), (k == 0) ? m0_ready : m1_ready, 1);
    check($sformatf("issue%0d_rf_we", k), rf_we, we);
    check($sformatf("issue%0d_rf_addr", k), rf_addr, a);
    step();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 21'h1F0F0 + i;  // garbage before clear
    arst_n = 1'b0; cke = 1'b1; clr = 1'b0;
    m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    #3;
    check("rst_init_done", init_done, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    check("rst_m0_rdata", m0_rdata, 0);
    check("rst_rf_we", rf_we, 1);
    check("rst_rf_addr", rf_addr, 0);

    // Sweep after reset release; a pending read must not be granted in INIT
    @(posedge clk); #1; arst_n = 1'b1; m0_valid = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sweep_we_%0d", i), rf_we, 1);
      check($sformatf("sweep_addr_%0d", i), rf_addr, i);
      check($sformatf("sweep_d_%0d", i), rf_d_o, 0);
      check($sformatf("sweep_rdy0_%0d", i), m0_ready, 0);
      check($sformatf("sweep_done_%0d", i), init_done, 0);
      step();
    end
    m0_valid = 1'b0; #1;
    check("run_init_done", init_done, 1);

    // Read of cleared address 2
    issue(0, 1'b0, 2'd2, '0);
    check("rd2_rvalid", m0_rvalid, 1);
    check("rd2_rdata", m0_rdata, 0);
    step();
    check("rd2_rvalid_drop", m0_rvalid, 0);

    // m1 write 0x1ABCD to address 3, then read it back (pointer ends at 0)
    issue(1, 1'b1, 2'd3, 21'h1ABCD);
    check("wr3_no_rvalid", m1_rvalid, 0);
    issue(1, 1'b0, 2'd3, '0);
    check("rd3_m1_rvalid", m1_rvalid, 1);
    check("rd3_m1_rdata", m1_rdata, 21'h1ABCD);
    check("rd3_m0_rvalid", m0_rvalid, 0);
    step();
    check("rd3_m1_rvalid_drop", m1_rvalid, 0);

    // Contention, both held: grants alternate 0,1,0,1
    m0_valid = 1; m0_we = 1; m0_addr = 2'd0; m0_wdata = 21'h11111;
    m1_valid = 1; m1_we = 1; m1_addr = 2'd1; m1_wdata = 21'h22222;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_rdy0_%0d", i), m0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr_rdy1_%0d", i), m1_ready, (i % 2 == 1) ? 1 : 0);
      check($sformatf("rr_addr_%0d", i), rf_addr, (i % 2 == 0) ? 0 : 1);
      step();
    end
    m0_valid = 0; m1_valid = 0; #1;
    check("mem0_written", mem[0], 21'h11111);
    check("mem1_written", mem[1], 21'h22222);

    // Read right after write to the same address returns new data
    issue(0, 1'b1, 2'd2, 21'h0BEEF);
    issue(0, 1'b0, 2'd2, '0);
    check("raw_rvalid", m0_rvalid, 1);
    check("raw_rdata", m0_rdata, 21'h0BEEF);

    // Clear in RUN with m0 valid: not accepted, no write
    m0_valid = 1; m0_we = 1; m0_addr = 2'd0; m0_wdata = 21'h00055; clr = 1; #1;
    check("clr_rdy0", m0_ready, 0);
    check("clr_rf_we", rf_we, 0);
    step();
    m0_valid = 0; clr = 0; #1;
    check("clr_init_done", init_done, 0);
    check("clr_sweep_addr0", rf_addr, 0);
    step();
    // clr during INIT is ignored
    clr = 1; #1;
    check("clr_sweep_addr1", rf_addr, 1);
    step();
    clr = 0; #1;
    check("clr_ignored_addr2", rf_addr, 2);
    // clock enable low freezes the sweep for 3 cycles
    cke = 0; m0_valid = 1; #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cke_we_%0d", i), rf_we, 0);
      check($sformatf("cke_addr_%0d", i), rf_addr, 2);
      check($sformatf("cke_rdy0_%0d", i), m0_ready, 0);
      step();
    end
    cke = 1; m0_valid = 0; #1;
    check("cke_resume_we", rf_we, 1);
    check("cke_resume_addr", rf_addr, 2);
    step();
    check("sweep_addr3", rf_addr, 3);
    step();
    check("clr_done", init_done, 1);
    issue(0, 1'b0, 2'd2, '0);
    check("clr_rd2_rdata", m0_rdata, 0);
    check("clr_rd2_rvalid", m0_rvalid, 1);

    // Reset with a read outstanding (pointer now 1 after m0 grant)
    issue(0, 1'b0, 2'd3, '0);
    check("pre_rst_rvalid", m0_rvalid, 1);
    arst_n = 0; #1;
    check("arst_rvalid", m0_rvalid, 0);
    check("arst_done", init_done, 0);
    check("arst_addr", rf_addr, 0);
    step();
    arst_n = 1; #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("resweep_addr_%0d", i), rf_addr, i);
      step();
    end
    // pointer reset to 0: tie goes to m0
    m0_valid = 1; m0_we = 0; m0_addr = 0;
    m1_valid = 1; m1_we = 0; m1_addr = 1; #1;
    check("post_rst_rdy0", m0_ready, 1);
    check("post_rst_rdy1", m1_ready, 0);
    step();
    m0_valid = 0; m1_valid = 0; #1;
    check("post_rst_rdata", m0_rdata, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iob_regfile_sp_arb.md
IOB_REGFILE_SP_ARB -- requirements
Module: iob_regfile_sp_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 2, meaning the register file address width (2**ADDR_W entries).
REQ-002 The block SHALL have parameter DATA_W, default 21, meaning the register file word width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port arst_n_i, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port cke_i, input, 1, clock enable; when low, all state SHALL hold, m*_ready_o SHALL be 0 and rf_we_o SHALL be 0.
REQ-006 The block SHALL have port clr_i, input, 1, synchronous request to re-clear every entry to zero.
REQ-007 The block SHALL have port init_done_o, output, 1, high while the controller is in RUN.
REQ-008 For each requester k in {0,1}, the block SHALL have: mk_valid_i (input, 1, request valid), mk_ready_o (output, 1, request accepted this cycle), mk_we_i (input, 1, 1=write, 0=read), mk_addr_i (input, ADDR_W, entry address), mk_wdata_i (input, DATA_W, write data), mk_rvalid_o (output, 1, read data valid pulse) and mk_rdata_o (output, DATA_W, read data).
REQ-009 The block SHALL have rf_we_o (output, 1), rf_addr_o (output, ADDR_W) and rf_d_o (output, DATA_W) driving the single-port register file, and rf_d_i (input, DATA_W) carrying its combinational read data for rf_addr_o.

Function
REQ-010 The controller SHALL have two states: INIT and RUN.
REQ-011 In INIT, the controller SHALL drive rf_we_o=1, rf_d_o=0 and rf_addr_o=init counter; the counter SHALL increment by 1 each enabled cycle, and after writing address 2**ADDR_W-1 it SHALL wrap to 0 and the state SHALL move to RUN, so INIT lasts exactly 2**ADDR_W enabled cycles.
REQ-012 In INIT, m0_ready_o and m1_ready_o SHALL be 0.
REQ-013 In RUN with clr_i=1, the controller SHALL grant no request that cycle, SHALL drive rf_we_o=0, and SHALL enter INIT with counter 0 on the next edge.
REQ-014 clr_i SHALL be ignored in INIT, and an in-progress sweep SHALL NOT restart.
REQ-015 In RUN, at most one request SHALL be accepted per cycle; acceptance is mk_valid_i & mk_ready_o.
REQ-016 Arbitration SHALL be round-robin with a 1-bit priority pointer: when only one mk_valid_i is high, that requester SHALL be granted; when both are high, the requester named by the pointer SHALL be granted.
REQ-017 After every accepted request, the pointer SHALL change to the non-granted requester; with no acceptance, it SHALL hold.
REQ-018 mk_ready_o SHALL be combinational from the state, clr_i, cke_i, both valids and the pointer, and SHALL NOT depend on mk_ready_o.
REQ-019 In RUN, rf_addr_o and rf_d_o SHALL take the granted requester's mk_addr_i and mk_wdata_i, and rf_we_o SHALL equal the granted request's mk_we_i; with no grant, rf_we_o SHALL be 0.
REQ-020 For an accepted write, the entry SHALL update at the end of the acceptance cycle, and no mk_rvalid_o SHALL be produced.
REQ-021 For an accepted read, mk_rdata_o SHALL register rf_d_i in the acceptance cycle, and mk_rvalid_o SHALL pulse high for exactly the following cycle; otherwise mk_rvalid_o SHALL be 0 and mk_rdata_o SHALL hold.
REQ-022 Reads SHALL be accepted back-to-back every cycle, with throughput 1 access/cycle in total and latency 1 cycle.
REQ-023 A read issued in the cycle after a write to the same address SHALL return the new data.
REQ-024 A held request whose mk_valid_i stays high without acceptance SHALL NOT cause any register file access.

Reset
REQ-025 On arst_n_i=0, asynchronously: state=INIT, counter=0, pointer=0 (requester 0 favoured), mk_rvalid_o=0, mk_rdata_o=0, init_done_o=0.
REQ-026 Reset during INIT or RUN SHALL abort any sweep or access, and on release the sweep SHALL restart from address 0.

Verification
REQ-027 Reset release with ADDR_W=2: rf_we_o=1 and rf_addr_o=0,1,2,3 with rf_d_o=0 over 4 cycles, then init_done_o=1, and a read of address 2 returns 0.
REQ-028 Contention: m0 and m1 both write at once from pointer=0 -> m0 granted, then m1 granted next cycle; both keep valid asserted -> grants alternate 0,1,0,1.
REQ-029 Read latency: m1 writes 0x1ABCD to address 3, then m1 reads address 3 -> m1_rvalid_o high 1 cycle later with m1_rdata_o=0x1ABCD, and m0_rvalid_o stays 0.
REQ-030 clr_i in RUN with m0 valid -> m0 not accepted; 4 INIT cycles follow; then the previously written address reads 0.
REQ-031 cke_i=0 mid-sweep for 3 cycles -> counter, rf_we_o=0 and ready outputs frozen; the sweep resumes at the same address when cke_i returns to 1.
REQ-032 arst_n_i pulsed low while m0 has a read outstanding -> m0_rvalid_o=0 immediately, and the sweep restarts from address 0.
